// File: rtl/alu_md_pkg.sv
// Shared encodings for alu_md: ALU function codes, MD op codes, default MD latencies.
// Pure declarations; no latency or backpressure of its own.
package alu_md_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO: busy for MULT_LAT/DIV_LAT cycles after an accepted op, mthi/mtlo in one edge.
// No queuing: md_start is only taken while busy is low; requests during busy are dropped.
module md_unit
  import alu_md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic               signed_op, is_mult, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

  // Arithmetic is single-shot on the latched operands; the counter alone sets the visible latency.
  always_comb begin
    is_mult   = (op_q == MD_MULT) || (op_q == MD_MULTU);
    signed_op = (op_q == MD_MULT) || (op_q == MD_DIV);
    a_neg     = signed_op & a_q[WIDTH-1];
    b_neg     = signed_op & b_q[WIDTH-1];
    a_ext     = {{WIDTH{a_neg}}, a_q};
    b_ext     = {{WIDTH{b_neg}}, b_q};
    prod      = a_ext * b_ext;
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    // Divide-by-zero result is discarded; a dummy divisor keeps the operator well defined.
    divisor   = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag     = a_mag / divisor;
    r_mag     = a_mag % divisor;
    quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem       = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state_d = MD_RUN;
              cnt_d   = MULT_CNT;
              a_d     = a;
              b_d     = b;
              op_d    = md_op;
            end
            MD_DIV, MD_DIVU: begin
              state_d = MD_RUN;
              cnt_d   = DIV_CNT;
              a_d     = a;
              b_d     = b;
              op_d    = md_op;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = MD_IDLE;
          if (is_mult) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU (combinational, zero latency) plus md_unit (busy/start handshake; pipeline stalls on busy).
// Optional signed-overflow output ovf on add/sub when ALU_OVF_EN is defined.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sum, diff;
  logic             slt_s, slt_u;

  assign shamt = B[SH_W-1:0];
  assign sum   = A + B;
  assign diff  = A - B;
  assign slt_s = $signed(A) < $signed(B);
  assign slt_u = A < B;

  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD:  C = sum;
      ALU_SUB:  C = diff;
      ALU_AND:  C = A & B;
      ALU_OR:   C = A | B;
      ALU_SRL:  C = A >> shamt;
      ALU_SRA:  C = $signed(A) >>> shamt;
      ALU_XOR:  C = A ^ B;
      ALU_NOR:  C = ~(A | B);
      ALU_SLL:  C = A << shamt;
      ALU_SLT:  C = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_SLTU: C = {{(WIDTH-1){1'b0}}, slt_u};
      default:  C = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    ovf = 1'b0;
    if (ALUOp == ALU_ADD)
      ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    else if (ALUOp == ALU_SUB)
      ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  end
`endif

  md_unit #(
    .WIDTH    (WIDTH),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_unit (
    .clk      (clk),
    .reset    (reset),
    .a        (A),
    .b        (B),
    .md_start (md_start),
    .md_op    (md_op),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: ALU vectors, MD handshake/latency, ignored starts, reset abort.
// Overflow vectors are included when ALU_OVF_EN is defined.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  A, B, C, hi, lo;
  logic [3:0]    ALUOp;
  logic          md_start, busy;
  logic [2:0]    md_op;
`ifdef ALU_OVF_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_md #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALUOp    (ALUOp),
    .C        (C),
    .md_start (md_start),
    .md_op    (md_op),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
`ifdef ALU_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
    ALUOp = op;
    A     = a;
    B     = b;
    #1;
    check(tag, 64'(C), 64'(exp));
  endtask

  // Issues one MD request, then counts busy cycles and notes whether hi/lo moved while busy.
  task automatic run_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n, output logic held);
    logic [W-1:0] prev_hi, prev_lo;
    prev_hi  = hi;
    prev_lo  = lo;
    md_op    = op;
    A        = a;
    B        = b;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    n        = 0;
    held     = 1'b1;
    while (busy && n < 100) begin
      n++;
      if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
      tick();
    end
  endtask

  int   n;
  logic held;

  initial begin
    reset    = 1'b1;
    A        = '0;
    B        = '0;
    ALUOp    = '0;
    md_start = 1'b0;
    md_op    = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);

    alu_vec("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    alu_vec("sub_wrap", ALU_SUB,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF);
    alu_vec("and",      ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    alu_vec("or",       ALU_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    alu_vec("xor",      ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    alu_vec("nor",      ALU_NOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F);
    alu_vec("sra",      ALU_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    alu_vec("srl",      ALU_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    alu_vec("sll",      ALU_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000);
    alu_vec("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu_vec("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu_vec("slt_rev",  ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    alu_vec("sltu_rev", ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    alu_vec("op11",     4'd11,    32'h0000_0005, 32'h0000_0003, 32'h0000_0000);
    alu_vec("op15",     4'd15,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

`ifdef ALU_OVF_EN
    alu_vec("ovf_add_c", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    check("ovf_add", 64'(ovf), 64'd1);
    alu_vec("ovf_sub_c", ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF);
    check("ovf_sub", 64'(ovf), 64'd1);
    alu_vec("ovf_none_c", ALU_ADD, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
    check("ovf_none", 64'(ovf), 64'd0);
`endif

    run_md(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, n, held);
    check("mult_cycles", 64'(n), 64'd5);
    check("mult_held",   64'(held), 64'd1);
    check("mult_hi",     64'(hi), 64'hFFFF_FFFF);
    check("mult_lo",     64'(lo), 64'hFFFF_FFFE);

    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, n, held);
    check("multu_cycles", 64'(n), 64'd5);
    check("multu_hi",     64'(hi), 64'h0000_0001);
    check("multu_lo",     64'(lo), 64'hFFFF_FFFE);

    run_md(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, n, held);
    check("div_cycles", 64'(n), 64'd10);
    check("div_held",   64'(held), 64'd1);
    check("div_lo",     64'(lo), 64'hFFFF_FFFD);
    check("div_hi",     64'(hi), 64'hFFFF_FFFF);

    run_md(MD_DIVU, 32'd100, 32'd7, n, held);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, held);
    check("divmin_lo", 64'(lo), 64'h8000_0000);
    check("divmin_hi", 64'(hi), 64'h0000_0000);

    run_md(MD_MTHI, 32'h0000_0011, 32'h0, n, held);
    check("mthi_busy", 64'(n), 64'd0);
    run_md(MD_MTLO, 32'h0000_0022, 32'h0, n, held);
    check("mthi_val", 64'(hi), 64'h11);
    check("mtlo_val", 64'(lo), 64'h22);

    run_md(MD_DIV, 32'd5, 32'd0, n, held);
    check("div0_cycles", 64'(n), 64'd10);
    check("div0_hi",     64'(hi), 64'h11);
    check("div0_lo",     64'(lo), 64'h22);

    // mthi offered in busy cycle 3 of a mult must vanish.
    md_op    = MD_MULT;
    A        = 32'h0001_0000;
    B        = 32'h0001_0000;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      if (busy) n++;
      tick();
    end
    md_op    = MD_MTHI;
    A        = 32'h0000_DEAD;
    md_start = 1'b1;
    if (busy) n++;
    tick();
    md_start = 1'b0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("ign_cycles", 64'(n), 64'd5);
    check("ign_hi",     64'(hi), 64'h0000_0001);
    check("ign_lo",     64'(lo), 64'h0000_0000);

    // First idle cycle after busy: accepted immediately.
    md_op    = MD_MTLO;
    A        = 32'h0000_1234;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    check("mtlo_b2b",  64'(lo), 64'h0000_1234);
    check("mtlo_busy", 64'(busy), 64'd0);

    md_op    = MD_DIV;
    A        = 32'd100;
    B        = 32'd7;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("abort_busy_pre", 64'(busy), 64'd1);
    reset    = 1'b1;
    md_op    = MD_MTHI;
    A        = 32'h0000_0055;
    md_start = 1'b1;
    tick();
    reset    = 1'b0;
    md_start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi",   64'(hi), 64'd0);
    check("abort_lo",   64'(lo), 64'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_late_hi",   64'(hi), 64'd0);
    check("abort_late_lo",   64'(lo), 64'd0);
    check("abort_late_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle 32-bit ALU.
- Keeps a combinational ALU path, with a wider op set and a defined shift-amount rule.
- Adds a sequential multiply/divide unit with HI/LO registers and a start/busy handshake.
- Sits in the EX stage of the MIPS pipeline. The hazard unit stalls on busy.

Parameters:
- WIDTH, 32, datapath width. Power of two, 8 or more.
- MULT_LAT, 5, cycles busy is held for mult/multu. Must be 1 or more.
- DIV_LAT, 10, cycles busy is held for div/divu. Must be 1 or more.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand A (rs).
- B  in  WIDTH  operand B (rt/imm).
- ALUOp  in  4  combinational ALU function select.
- C  out  WIDTH  combinational ALU result.
- md_start  in  1  request for an MD operation this cycle.
- md_op  in  3  MD operation select.
- busy  out  1  MD unit busy; the pipeline must stall MD ops and mfhi/mflo while it is high.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- ovf  out  1  signed overflow flag. Present only with ALU_OVF_EN.

Behaviour:
- ALU path is purely combinational, zero latency. ALUOp encoding:
  - 0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra, 6 xor, 7 nor, 8 sll.
  - 9 slt (signed, result 1/0 zero-extended), 10 sltu.
  - 11..15 give C=0.
- Shifts use only B[$clog2(WIDTH)-1:0] as the shift amount; the upper bits of B are ignored.
- add/sub wrap modulo 2^WIDTH.
- md_op encoding: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are a no-op.
- Accept rule: a request is accepted only when md_start=1 and busy=0 at a clock edge. A request while busy=1 is ignored entirely: no queuing, no operand latch.
- mthi/mtlo: hi or lo takes A at the accepting edge. busy stays 0.
- mult/multu/div/divu:
  - At the accepting edge, A, B and md_op are latched, and a down-counter loads the op's latency (MULT_LAT or DIV_LAT).
  - busy is high for exactly that many cycles after the accepting edge.
  - At the edge where the counter reaches 0, {hi,lo} are written and busy falls together.
  - hi/lo hold their old values for the whole busy period.
  - Back-to-back operations: a new start is accepted on the first cycle busy is 0.
- Multiply results: mult gives {hi,lo} = signed A*B as a 2*WIDTH product; multu gives the unsigned product.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - divu is the unsigned equivalent.
  - Divide by zero: busy runs the full DIV_LAT, then hi/lo are left unchanged.
  - Signed MIN / -1: lo = MIN, hi = 0.
- Implementation of the arithmetic is free (single-shot or iterative), but the visible latency is fixed by the parameters.
- State machine:
  - IDLE goes to RUN on an accepted mult/div.
  - RUN decrements the counter and goes back to IDLE, writing hi/lo, when the counter hits 0.
- Reset (synchronous, any state, including mid-operation): busy=0, hi=0, lo=0, counter=0, state IDLE. An in-flight operation is discarded. md_start in the same cycle as reset is ignored.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined: the ovf output exists. It is 1 when ALUOp is add or sub and signed two's-complement overflow occurs; otherwise it is 0. Combinational. C is unchanged either way.
- Undefined: there is no ovf port and no overflow logic.

Decomposition:
- Package alu_md_pkg holds:
  - ALUOp codes, as a 4-bit localparam set.
  - md_op codes, as a 3-bit localparam set.
  - Default MULT_LAT/DIV_LAT constants.
- One sub-module, md_unit. It contains the latch registers, counter, FSM and hi/lo, parametrised by WIDTH/MULT_LAT/DIV_LAT.
- The top level instantiates md_unit and holds the combinational ALU mux.

Test Plan:
- ALU shifts: ALUOp=5, A=0x80000000, B=0x00000024 → C=0xF8000000 (shift of 4). ALUOp=4, same inputs → C=0x08000000. ALUOp=9, A=0xFFFFFFFF, B=1 → C=1. ALUOp=10, same inputs → C=0.
- mult handshake: mult with A=0xFFFFFFFF, B=2 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div: div with A=0xFFFFFFF9 (-7), B=2 → after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. div by zero with prior hi=0x11, lo=0x22 → hi/lo unchanged after 10 cycles.
- Ignored starts: md_start with mthi during busy cycle 3 of a mult → ignored, final hi is the product. mtlo with A=0x1234 while idle → lo=0x1234 next edge, busy stays 0.
- Reset abort: assert reset in busy cycle 4 of a div → next edge gives busy=0, hi=lo=0. No late write-back occurs afterwards.
- ALU_OVF_EN build: ALUOp=0, A=0x7FFFFFFF, B=1 → C=0x80000000, ovf=1. ALUOp=1, A=0x80000000, B=1 → ovf=1. ALUOp=0, A=1, B=1 → ovf=0.
